count_bank: RTL and testbench

- 32-channel pulse counter bank. Sits directly upstream of the Ethernet/SOPC top and drives its ch1..ch32 count inputs.
- Consumes that top's start-run strobe and counter-read strobe. Returns its stop-run status.
- Counts rising edges of asynchronous discriminator pulses during a programmable gate. Presents a stable snapshot for readout.

---
 rtl/count_pkg.sv | 18 +
 rtl/count_bank_chan_counter.sv | 54 +++++
 rtl/count_bank.sv | 116 +++++++++++
 tb/tb_count_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared constants, FSM state type and slice helper for the count_bank pulse counter.
package count_pkg;

  localparam int NCH = 32;
  localparam int CW  = 32;
  localparam int GW  = 32;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/count_bank_chan_counter.sv
// One channel: synchroniser, rising-edge detector and saturating counter with sticky ovf.
// cnt presents the value the counter holds after the coming edge, so a snapshot includes this cycle's increment.
module chan_counter #(
  parameter int CW   = 32,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pulse,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  logic [SYNC-1:0] sync_q;
  logic            hist_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            rise;

  assign rise = sync_q[SYNC-1] & ~hist_q;

  // Clear wins over counting, so edges in the start cycle are dropped.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en && rise) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pulse};
      hist_q <= sync_q[SYNC-1];
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt = cnt_d;
  assign ovf = ovf_q;

endmodule

// File: rtl/count_bank.sv
// Gated 32-channel pulse counter bank: run FSM, gate timer, strobe edge detection and snapshot bank.
module count_bank #(
  parameter int NCH  = count_pkg::NCH,
  parameter int CW   = count_pkg::CW,
  parameter int GW   = count_pkg::GW,
  parameter int SYNC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NCH-1:0]     pulse_in,
  input  logic               start_step,
  input  logic               cread,
  input  logic [GW-1:0]      gate_len,
  output logic               stop_step,
  output logic               busy,
  output logic [NCH*CW-1:0]  count_flat,
  output logic [NCH-1:0]     ovf
);
  import count_pkg::*;

  state_e              state_q, state_d;
  logic [GW-1:0]       timer_q, timer_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic                start_hist_q, cread_hist_q;
  logic                start_rise, cread_rise;
  logic                cnt_en, cnt_clr, end_gate, zero_start;
  logic [NCH*CW-1:0]   live_flat;
  logic [NCH*CW-1:0]   snap_q, snap_d;

  assign start_rise = start_step & ~start_hist_q;
  assign cread_rise = cread & ~cread_hist_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    chan_counter #(.CW(CW), .SYNC(SYNC)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .pulse   (pulse_in[k]),
      .en      (cnt_en),
      .clr     (cnt_clr),
      .cnt     (live_flat[slice_off(k, CW) +: CW]),
      .ovf     (ovf[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    stop_d     = stop_q;
    busy_d     = busy_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    end_gate   = 1'b0;
    zero_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          cnt_clr = 1'b1;
          timer_d = gate_len;
          if (gate_len == '0) begin
            zero_start = 1'b1;
            state_d    = DONE;
            stop_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d = COUNT;
            stop_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      COUNT: begin
        cnt_en  = 1'b1;
        timer_d = timer_q - GW'(1);
        if (timer_q == GW'(1)) begin
          end_gate = 1'b1;
          state_d  = DONE;
          stop_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // live_flat is already zero on a zero-length start because the counters are being cleared.
  always_comb begin
    snap_d = snap_q;
    if (cread_rise || end_gate || zero_start) snap_d = live_flat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      start_hist_q <= 1'b0;
      cread_hist_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      start_hist_q <= start_step;
      cread_hist_q <= cread;
      snap_q       <= snap_d;
    end
  end

  assign stop_step  = stop_q;
  assign busy       = busy_q;
  assign count_flat = snap_q;

endmodule

// File: tb/tb_count_bank.sv
// Directed bench for count_bank: a 32-bit build and an 8-bit build share the same stimulus.
module tb_count_bank;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   pulse_in = '0;
  logic          start_step = 1'b0;
  logic          cread = 1'b0;
  logic [31:0]   gate_len = '0;

  logic          stop32, busy32, stop8, busy8;
  logic [1023:0] flat32;
  logic [255:0]  flat8;
  logic [31:0]   ovf32, ovf8;

  int n_cmp = 0;
  int n_err = 0;

  count_bank #(.NCH(32), .CW(32), .GW(32), .SYNC(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .start_step(start_step),
    .cread(cread), .gate_len(gate_len), .stop_step(stop32), .busy(busy32),
    .count_flat(flat32), .ovf(ovf32)
  );

  count_bank #(.NCH(32), .CW(8), .GW(32), .SYNC(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .start_step(start_step),
    .cread(cread), .gate_len(gate_len), .stop_step(stop8), .busy(busy8),
    .count_flat(flat8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every channel of the 32-bit build must read 0 except channel ch (1-based) which reads val.
  task automatic check_snap(input string tag, input int ch, input logic [31:0] val);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_ch%0d", tag, k + 1), 64'(flat32[k*32 +: 32]),
            (k == ch - 1) ? 64'(val) : 64'd0);
  endtask

  task automatic do_start(input logic [31:0] len);
    gate_len   = len;
    start_step = 1'b1;
    tick(1);
    start_step = 1'b0;
  endtask

  task automatic do_cread();
    cread = 1'b1;
    tick(1);
    cread = 1'b0;
  endtask

  task automatic pulse(input int ch, input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      pulse_in[ch-1] = 1'b1;
      tick(h);
      pulse_in[ch-1] = 1'b0;
      tick(l);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("rst_stop", 64'(stop32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_ovf", 64'(ovf32), 64'd0);
    check_snap("rst_snap", 0, 32'd0);

    // gate 100, ten pulses inside, three after
    do_start(32'd100);
    check("g100_busy_start", 64'(busy32), 64'd1);
    pulse(1, 10, 2, 3);
    tick(49);
    check("g100_stop_early", 64'(stop32), 64'd0);
    check("g100_busy_mid", 64'(busy32), 64'd1);
    tick(1);
    check("g100_stop_end", 64'(stop32), 64'd1);
    check("g100_busy_end", 64'(busy32), 64'd0);
    check_snap("g100_snap", 1, 32'd10);
    pulse(1, 3, 2, 3);
    do_cread();
    check_snap("g100_after", 1, 32'd10);
    check("g100_busy_after", 64'(busy32), 64'd0);

    // gate 1000, toggling ch5, mid-run read then final count
    do_start(32'd1000);
    pulse(5, 200, 1, 1);
    tick(4);
    do_cread();
    check_snap("g1k_partial", 5, 32'd200);
    check("g1k_busy_mid", 64'(busy32), 64'd1);
    pulse(5, 150, 1, 1);
    check_snap("g1k_hold", 5, 32'd200);
    tick(294);
    check("g1k_stop_early", 64'(stop32), 64'd0);
    tick(1);
    check("g1k_stop_end", 64'(stop32), 64'd1);
    check_snap("g1k_final", 5, 32'd350);
    tick(3);
    do_cread();
    check_snap("g1k_reread", 5, 32'd350);

    // start re-issued during COUNT leaves the 50-cycle gate intact
    do_start(32'd50);
    tick(10);
    start_step = 1'b1;
    tick(1);
    start_step = 1'b0;
    pulse(1, 2, 2, 3);
    tick(28);
    check("restart_stop_early", 64'(stop32), 64'd0);
    check("restart_busy_mid", 64'(busy32), 64'd1);
    tick(1);
    check("restart_stop_end", 64'(stop32), 64'd1);
    check_snap("restart_snap", 1, 32'd2);

    // reset mid-run aborts without a snapshot
    do_start(32'd50);
    pulse(1, 3, 2, 3);
    check("midrst_busy_pre", 64'(busy32), 64'd1);
    reset_n = 1'b0;
    #2;
    check("midrst_busy_async", 64'(busy32), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("midrst_stop", 64'(stop32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_ovf", 64'(ovf32), 64'd0);
    check_snap("midrst_snap", 0, 32'd0);
    tick(60);
    check("midrst_stop_late", 64'(stop32), 64'd0);
    check_snap("midrst_snap_late", 0, 32'd0);

    // zero-length gate
    do_start(32'd0);
    check("g0_stop", 64'(stop32), 64'd1);
    check("g0_busy", 64'(busy32), 64'd0);
    tick(1);
    check("g0_busy_next", 64'(busy32), 64'd0);
    check_snap("g0_snap", 0, 32'd0);

    // 300 pulses on ch3: 8-bit build saturates and flags ovf
    do_start(32'd1000);
    pulse(3, 300, 1, 1);
    tick(399);
    check("sat_stop_early", 64'(stop32), 64'd0);
    tick(1);
    check("sat_stop_end", 64'(stop32), 64'd1);
    check_snap("sat_snap32", 3, 32'd300);
    check("sat_ovf32", 64'(ovf32), 64'd0);
    check("sat_cnt8", 64'(flat8[2*8 +: 8]), 64'd255);
    check("sat_cnt8_ch2", 64'(flat8[1*8 +: 8]), 64'd0);
    check("sat_ovf8", 64'(ovf8), 64'h4);
    check("sat_stop8", 64'(stop8), 64'd1);

    // next start clears ovf and a zero gate snapshots zeros
    do_start(32'd0);
    check("clr_ovf8", 64'(ovf8), 64'd0);
    check("clr_cnt8", 64'(flat8[2*8 +: 8]), 64'd0);
    check_snap("clr_snap32", 0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
